latch_wr_sched: RTL and testbench
=================================

LATCH_WR_SCHED -- requirements
Module: latch_wr_sched

Interface
REQ-001 The block SHALL have parameter DW, default 8: width of the data written into the latch bank.
REQ-002 The block SHALL have parameter AW, default 3: latch-bank address width, giving 2**AW latch words.
REQ-003 The block SHALL have parameter SETUP_CYC, default 1 (legal >=1): number of cycles LAT_D is stable before LAT_EN rises.
REQ-004 The block SHALL have parameter PW_CYC, default 2 (legal >=1): number of cycles LAT_EN stays high (minimum-pulse-width guarantee).
REQ-005 The block SHALL have parameter HOLD_CYC, default 1 (legal >=1): number of cycles LAT_D stays stable after LAT_EN falls.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have ports REQ_A and REQ_B, inputs, 1 bit each: write requests, held high until the matching ACK.
REQ-009 The block SHALL have ports ADDR_A and ADDR_B, inputs, AW bits each: target latch word.
REQ-010 The block SHALL have ports DATA_A and DATA_B, inputs, DW bits each: write data.
REQ-011 The block SHALL have ports ACK_A and ACK_B, outputs, 1 bit each: one-cycle completion pulse.
REQ-012 The block SHALL have port LAT_D, output, DW bits: shared data bus to the D pins of the latch bank.
REQ-013 The block SHALL have port LAT_EN, output, 2**AW bits: per-word latch enable, one-hot or all-zero.
REQ-014 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETUP, PULSE and HOLD.
REQ-016 In IDLE with REQ_A or REQ_B high, the block SHALL, at the next edge: select a winner, register the winner's address and data, and enter SETUP.
REQ-017 Arbitration SHALL be two-way round-robin: a pointer indicates the favoured requester, and after every grant it moves to the non-winner.
REQ-018 The round-robin pointer SHALL reset to favour A.
REQ-019 SETUP SHALL last SETUP_CYC cycles, PULSE SHALL last PW_CYC cycles and HOLD SHALL last HOLD_CYC cycles; after HOLD the FSM SHALL return to IDLE.
REQ-020 A single down-counter SHALL time all three phases; its width SHALL be the ceiling of log2 of the largest of SETUP_CYC, PW_CYC and HOLD_CYC, plus 1.
REQ-021 LAT_D SHALL equal the captured data throughout SETUP, PULSE and HOLD, and SHALL hold its last value in IDLE.
REQ-022 LAT_EN SHALL be one-hot at the captured address in PULSE only, and all-zero in every other state.
REQ-023 LAT_EN SHALL be driven directly from a flop, with no glitch.
REQ-024 The winner's ACK SHALL be high exactly during the final HOLD cycle; the other ACK SHALL stay low.
REQ-025 A requester deasserting REQ mid-transaction SHALL be ignored; the transaction completes and is still acked.
REQ-026 A REQ that is held high during a transaction SHALL be arbitrated in the next IDLE cycle.
REQ-027 Service cost SHALL be 1 IDLE cycle plus SETUP_CYC + PW_CYC + HOLD_CYC cycles per write.
REQ-028 Inputs SHALL be sampled only in IDLE; changes to ADDR or DATA after capture SHALL have no effect.

Reset
REQ-029 While RST is high at an edge, the block SHALL enter IDLE and drive LAT_EN=0, ACK_A=0, ACK_B=0, BUSY=0, LAT_D=0 and counter=0, and set the pointer to A.
REQ-030 If RST is asserted during PULSE, LAT_EN SHALL drop at that same edge; the aborted write SHALL never be acked.

Structure
REQ-031 The package latch_sched_pkg SHALL hold the state enum (IDLE, SETUP, PULSE, HOLD) and the default parameter constants.
REQ-032 The block SHALL contain one sub-module, rr_arb2: a two-input round-robin arbiter with registered pointer, inputs req[1:0] and advance, output one-hot gnt[1:0].

Verification
REQ-033 With defaults, REQ_A, ADDR_A=5 and DATA_A=0xA5 sampled at edge 0 SHALL give: SETUP in cycle 1; LAT_EN=0x20 in cycles 2-3; HOLD with ACK_A=1 in cycle 4; IDLE in cycle 5; LAT_D=0xA5 in cycles 1-4.
REQ-034 With REQ_A and REQ_B both held high from reset, grants SHALL be A, B, A, B and each ACK SHALL be spaced 5 cycles apart.
REQ-035 With PW_CYC=1, SETUP_CYC=3 and HOLD_CYC=2, LAT_EN SHALL be high for exactly 1 cycle, preceded by 3 and followed by 2 cycles of stable LAT_D.
REQ-036 RST asserted in the first PULSE cycle SHALL give LAT_EN=0 and BUSY=0 on the next cycle, with no ACK; a subsequent REQ_B SHALL then be granted normally.
REQ-037 REQ_A dropped in SETUP and DATA_A changed to 0x00 SHALL leave LAT_D at the original value, and ACK_A SHALL still pulse in HOLD.
REQ-038 Every test SHALL check these invariants: $onehot0(LAT_EN); LAT_EN is never high outside PULSE; ACK_A and ACK_B are never high together.

Source files
------------

// File: rtl/latch_sched_pkg.sv
// Shared types and default constants for the latch-bank write scheduler.
// Also holds the helper that sizes the phase counter.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_DW        = 8;
    localparam int DEF_AW        = 3;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PW_CYC    = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_wr_sched_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// The pointer moves to the losing side whenever a grant is taken with advance high.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        // Winner 0 hands priority to 1, and vice versa.
        if (advance && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// Schedules writes from two requesters into a latch bank with guaranteed
// setup, enable-pulse width and hold around each latch-enable strobe.
module latch_wr_sched
    import latch_sched_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PW_CYC    = DEF_PW_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic [AW-1:0]     ADDR_A,
    input  logic [AW-1:0]     ADDR_B,
    input  logic [DW-1:0]     DATA_A,
    input  logic [DW-1:0]     DATA_B,
    output logic              ACK_A,
    output logic              ACK_B,
    output logic [DW-1:0]     LAT_D,
    output logic [(1<<AW)-1:0] LAT_EN,
    output logic              BUSY
);

    localparam int NW = 1 << AW;
    localparam int CW = $clog2(max3(SETUP_CYC, PW_CYC, HOLD_CYC)) + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            win_b_q, win_b_d;
    logic [NW-1:0]   lat_en_q, lat_en_d;
    logic [NW-1:0]   addr_onehot;
    logic [1:0]      gnt;

    rr_arb2 u_arb (
        .clk     (CLK),
        .srst    (RST),
        .req     ({REQ_B, REQ_A}),
        .advance (state_q == IDLE),
        .gnt     (gnt)
    );

    for (genvar gi = 0; gi < NW; gi++) begin : g_dec
        assign addr_onehot[gi] = (addr_q == AW'(gi));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        win_b_d = win_b_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    win_b_d = gnt[1];
                    addr_d  = gnt[1] ? ADDR_B : ADDR_A;
                    data_d  = gnt[1] ? DATA_B : DATA_A;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(PW_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Enable is decided one cycle ahead so the output comes straight off a flop.
        lat_en_d = (state_d == PULSE) ? addr_onehot : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            win_b_q  <= 1'b0;
            lat_en_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            win_b_q  <= win_b_d;
            lat_en_q <= lat_en_d;
        end
    end

    assign LAT_D  = data_q;
    assign LAT_EN = lat_en_q;
    assign BUSY   = (state_q != IDLE);
    assign ACK_A  = (state_q == HOLD) && (cnt_q == '0) && !win_b_q;
    assign ACK_B  = (state_q == HOLD) && (cnt_q == '0) &&  win_b_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed checks of the latch write scheduler: default-parameter vector table
// plus a hand sequence on a second instance with long setup/hold and a 1-cycle pulse.
module tb_latch_wr_sched;

    logic       CLK;
    logic       RST;
    logic       req_a, req_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, busy;
    logic [7:0] lat_d, lat_en;

    logic       req2_a;
    logic [2:0] addr2_a;
    logic [7:0] data2_a;
    logic       ack2_a, ack2_b, busy2;
    logic [7:0] lat2_d, lat2_en;

    int checks   = 0;
    int failures = 0;
    bit inv_on   = 0;

    latch_wr_sched u_dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(req_a), .REQ_B(req_b),
        .ADDR_A(addr_a), .ADDR_B(addr_b),
        .DATA_A(data_a), .DATA_B(data_b),
        .ACK_A(ack_a), .ACK_B(ack_b),
        .LAT_D(lat_d), .LAT_EN(lat_en), .BUSY(busy)
    );

    latch_wr_sched #(.DW(8), .AW(3), .SETUP_CYC(3), .PW_CYC(1), .HOLD_CYC(2)) u_dut2 (
        .CLK(CLK), .RST(RST),
        .REQ_A(req2_a), .REQ_B(1'b0),
        .ADDR_A(addr2_a), .ADDR_B(3'd0),
        .DATA_A(data2_a), .DATA_B(8'd0),
        .ACK_A(ack2_a), .ACK_B(ack2_b),
        .LAT_D(lat2_d), .LAT_EN(lat2_en), .BUSY(busy2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       rst, ra, rb;
        logic [2:0] aa, ab;
        logic [7:0] da, db;
        logic       busy;
        logic [7:0] en, d;
        logic       acka, ackb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ra, input logic rb,
                       input logic [2:0] aa, input logic [7:0] da,
                       input logic [2:0] ab, input logic [7:0] db,
                       input logic ebusy, input logic [7:0] een, input logic [7:0] ed,
                       input logic eacka, input logic eackb);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb;
        v.aa = aa; v.da = da; v.ab = ab; v.db = db;
        v.busy = ebusy; v.en = een; v.d = ed; v.acka = eacka; v.ackb = eackb;
        vecs.push_back(v);
    endtask

    // One complete single-requester write with default timing (1+1+2+1 cycles).
    task automatic add_write(input bit is_b, input logic [2:0] a, input logic [7:0] dat);
        logic [7:0] en;
        logic [2:0] aa, ab;
        logic [7:0] da, db;
        en = 8'd1 << a;
        aa = is_b ? 3'd0 : a;   ab = is_b ? a : 3'd0;
        da = is_b ? 8'd0 : dat; db = is_b ? dat : 8'd0;
        add(0, !is_b, is_b, aa, da, ab, db, 1, 8'h00, dat, 0, 0);
        add(0, !is_b, is_b, aa, da, ab, db, 1, en,    dat, 0, 0);
        add(0, !is_b, is_b, aa, da, ab, db, 1, en,    dat, 0, 0);
        add(0, !is_b, is_b, aa, da, ab, db, 1, 8'h00, dat, !is_b, is_b);
        add(0, 0,     0,    aa, da, ab, db, 0, 8'h00, dat, 0, 0);
    endtask

    // Continuous invariants on both instances.
    always @(negedge CLK) begin
        if (inv_on) begin
            check("inv_onehot0", {31'd0, $onehot0(lat_en)}, 32'd1);
            check("inv_en_outside_pulse", {31'd0, (lat_en != 0) && (!busy || ack_a || ack_b)}, 32'd0);
            check("inv_ack_both", {31'd0, ack_a && ack_b}, 32'd0);
            check("inv2_onehot0", {31'd0, $onehot0(lat2_en)}, 32'd1);
            check("inv2_ack_both", {31'd0, ack2_a && ack2_b}, 32'd0);
        end
    end

    initial begin
        logic [7:0] wd;
        logic       wb;
        RST = 1'b1; req_a = 0; req_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
        req2_a = 0; addr2_a = 0; data2_a = 0;

        // Reset state, then basic writes incl. address boundaries 0 and 7.
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        add_write(0, 3'd5, 8'hA5);
        add_write(0, 3'd0, 8'h5A);
        add_write(1, 3'd7, 8'hE7);

        // Both requesters held high from reset: A, B, A, B with acks 5 cycles apart.
        add(1, 1, 1, 3'd1, 8'h11, 3'd6, 8'h66, 0, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) begin
            wb = (k % 2) == 1;
            wd = wb ? 8'h66 : 8'h11;
            add(0, 1, 1, 3'd1, 8'h11, 3'd6, 8'h66, 1, 8'h00, wd, 0, 0);
            add(0, 1, 1, 3'd1, 8'h11, 3'd6, 8'h66, 1, wb ? 8'h40 : 8'h02, wd, 0, 0);
            add(0, 1, 1, 3'd1, 8'h11, 3'd6, 8'h66, 1, wb ? 8'h40 : 8'h02, wd, 0, 0);
            add(0, 1, 1, 3'd1, 8'h11, 3'd6, 8'h66, 1, 8'h00, wd, !wb, wb);
            add(0, k < 3, k < 3, 3'd1, 8'h11, 3'd6, 8'h66, 0, 8'h00, wd, 0, 0);
        end

        // REQ_A dropped and ADDR/DATA changed after capture: write completes unchanged.
        add(0, 1, 0, 3'd2, 8'h3C, 0, 8'h00, 1, 8'h00, 8'h3C, 0, 0);
        add(0, 0, 0, 3'd7, 8'h00, 0, 8'h00, 1, 8'h04, 8'h3C, 0, 0);
        add(0, 0, 0, 3'd7, 8'h00, 0, 8'h00, 1, 8'h04, 8'h3C, 0, 0);
        add(0, 0, 0, 3'd7, 8'h00, 0, 8'h00, 1, 8'h00, 8'h3C, 1, 0);
        add(0, 0, 0, 3'd7, 8'h00, 0, 8'h00, 0, 8'h00, 8'h3C, 0, 0);

        // Reset during the first PULSE cycle aborts the write; B is then served normally.
        add(0, 1, 0, 3'd3, 8'h77, 0, 8'h00, 1, 8'h00, 8'h77, 0, 0);
        add(0, 1, 0, 3'd3, 8'h77, 0, 8'h00, 1, 8'h08, 8'h77, 0, 0);
        add(1, 0, 0, 3'd3, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 3'd3, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        add_write(1, 3'd4, 8'h99);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; req_a = vecs[i].ra; req_b = vecs[i].rb;
            addr_a = vecs[i].aa; data_a = vecs[i].da;
            addr_b = vecs[i].ab; data_b = vecs[i].db;
            @(posedge CLK);
            #1;
            inv_on = 1;
            check($sformatf("v%0d_busy", i),  {31'd0, busy},  {31'd0, vecs[i].busy});
            check($sformatf("v%0d_lat_en", i), {24'd0, lat_en}, {24'd0, vecs[i].en});
            check($sformatf("v%0d_lat_d", i),  {24'd0, lat_d},  {24'd0, vecs[i].d});
            check($sformatf("v%0d_ack_a", i),  {31'd0, ack_a}, {31'd0, vecs[i].acka});
            check($sformatf("v%0d_ack_b", i),  {31'd0, ack_b}, {31'd0, vecs[i].ackb});
        end

        // Second instance: 3 setup cycles, 1-cycle pulse, 2 hold cycles.
        @(negedge CLK);
        RST = 0; req_a = 0; req_b = 0;
        req2_a = 1; addr2_a = 3'd6; data2_a = 8'hC3;
        for (int c = 1; c <= 7; c++) begin
            @(posedge CLK);
            #1;
            check($sformatf("p%0d_busy", c),   {31'd0, busy2},   {31'd0, c <= 6});
            check($sformatf("p%0d_lat_en", c), {24'd0, lat2_en}, (c == 4) ? 32'h40 : 32'h0);
            check($sformatf("p%0d_lat_d", c),  {24'd0, lat2_d},  32'hC3);
            check($sformatf("p%0d_ack_a", c),  {31'd0, ack2_a},  {31'd0, c == 6});
            @(negedge CLK);
            if (c == 1) data2_a = 8'h00;
            if (c == 6) req2_a = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
